sram_ctrl: RTL and testbench

//  Parametrised async-SRAM controller between the CPU control unit and the

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_ctrl.sv | 157 +++++++++++++++
 tb/tb_sram_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the async-SRAM controller: FSM state encoding and
// the width of the wait-state counter.
package sram_ctrl_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Async-SRAM controller: valid/ready request port in, registered active-low
// SRAM strobes out, one-cycle rsp_valid pulse per completed access.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                sram_cs_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_i
);

  localparam int BE_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("sram_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("sram_ctrl: WAIT_STATES must be in 0..15");
  end

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       dq_o_q, dq_o_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [BE_W-1:0]         be_n_q, be_n_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    accept;
  logic                    op_we;
  logic [BE_W-1:0]         op_be;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0) state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave flops aligned with it.
  always_comb begin
    op_we       = accept ? req_we : we_q;
    op_be       = accept ? req_be : be_q;
    cs_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = '1;
    dq_oe_d     = 1'b0;
    unique case (state_d)
      ST_SETUP: begin
        cs_n_d = 1'b0;
        oe_n_d = op_we;
        be_n_d = op_we ? ~op_be : '0;
      end
      ST_ACCESS: begin
        cs_n_d  = 1'b0;
        oe_n_d  = op_we;
        we_n_d  = !op_we;
        dq_oe_d = op_we;
        be_n_d  = op_we ? ~op_be : '0;
      end
      ST_HOLD: begin
        if (op_we) begin
          cs_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          be_n_d  = ~op_be;
        end
      end
      default: ;
    endcase
    rsp_valid_d = (state_d == ST_HOLD);

    cnt_d = cnt_q;
    if (accept) cnt_d = WAIT_CNT_W'(WAIT_STATES);
    else if (state_q == ST_ACCESS && cnt_q != '0) cnt_d = cnt_q - WAIT_CNT_W'(1);

    we_d    = accept ? req_we    : we_q;
    be_d    = accept ? req_be    : be_q;
    addr_d  = accept ? req_addr  : addr_q;
    dq_o_d  = accept ? req_wdata : dq_o_q;
    rdata_d = (state_q == ST_ACCESS && cnt_q == '0 && !we_q) ? sram_dq_i : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (0 and 3 wait states), each driving a
// behavioural SRAM model with a bus-contention monitor.
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [17:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [1:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        cs_n      [2];
  logic        oe_n      [2];
  logic        we_n      [2];
  logic [1:0]  be_n      [2];
  logic [17:0] addr      [2];
  logic [15:0] dq_o      [2];
  logic        dq_oe     [2];
  logic [15:0] dq_i      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(g == 0 ? 0 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .sram_cs_n(cs_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]),
      .sram_be_n(be_n[g]), .sram_addr(addr[g]), .sram_dq_o(dq_o[g]),
      .sram_dq_oe(dq_oe[g]), .sram_dq_i(dq_i[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: low 10 address bits index the array; undriven bus writes 0xEE.
  logic [15:0] mem [2][1024];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (!cs_n[g] && !we_n[g])
        for (int l = 0; l < 2; l++)
          if (!be_n[g][l])
            mem[g][addr[g][9:0]][l*8 +: 8] <= dq_oe[g] ? dq_o[g][l*8 +: 8] : 8'hEE;
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      dq_i[g] = 16'hBAD0;
      if (!cs_n[g] && !oe_n[g]) dq_i[g] = mem[g][addr[g][9:0]];
    end
  end

  int cont_err = 0;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++)
      if (dq_oe[g] && !oe_n[g]) cont_err <= cont_err + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input int s, input logic we, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        output logic [15:0] rd, output int lat, output int oe_cyc,
                        output int we_cyc, output logic [17:0] a_seen);
    int n;
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a;
    req_wdata[s] = d;    req_be[s] = be;
    lat = -1; oe_cyc = 0; we_cyc = 0; a_seen = '0; rd = '0;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready[s]) begin
      chk("accept_timeout", 64'(req_ready[s]), 64'd1);
      req_valid[s] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    a_seen = addr[s];
    for (int c = 0; c < 30 && lat < 0; c++) begin
      if (!oe_n[s]) oe_cyc++;
      if (!we_n[s]) we_cyc++;
      if (rsp_valid[s]) lat = c;
      else begin @(posedge clk); #1; end
    end
    rd = rsp_rdata[s];
  endtask

  typedef struct {
    int          s;
    logic        we;
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t        vt [11];
  logic [15:0] last_rd [2];
  logic        bw   [3];
  logic [15:0] bd   [3];
  logic [15:0] bexp [3];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic [17:0] a_seen;
    int lat, oe_cyc, we_cyc, ws, k, nrsp, rerr, seen;
    logic acc;

    vt[0]  = '{0, 1'b1, 18'h00010, 16'h1234, 2'b11, 16'h0000};
    vt[1]  = '{0, 1'b0, 18'h00010, 16'h0000, 2'b00, 16'h1234};
    vt[2]  = '{0, 1'b1, 18'h00020, 16'hAAAA, 2'b11, 16'h0000};
    vt[3]  = '{0, 1'b1, 18'h00020, 16'h5511, 2'b10, 16'h0000};
    vt[4]  = '{0, 1'b0, 18'h00020, 16'h0000, 2'b00, 16'h55AA};
    vt[5]  = '{0, 1'b1, 18'h00020, 16'hFFFF, 2'b00, 16'h0000};
    vt[6]  = '{0, 1'b0, 18'h00020, 16'h0000, 2'b00, 16'h55AA};
    vt[7]  = '{1, 1'b1, 18'h3FFFF, 16'hBEEF, 2'b11, 16'h0000};
    vt[8]  = '{1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'hBEEF};
    vt[9]  = '{1, 1'b1, 18'h3FFFF, 16'h0012, 2'b01, 16'h0000};
    vt[10] = '{1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'hBE12};

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0;   req_be[s] = '0;   last_rd[s] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_ctl%0d", s),
          64'({cs_n[s], oe_n[s], we_n[s], be_n[s], dq_oe[s], rsp_valid[s], req_ready[s]}),
          64'h0F9);
      chk($sformatf("reset_data%0d", s), 64'({addr[s], dq_o[s], rsp_rdata[s]}), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      ws = (vt[i].s == 0) ? 0 : 3;
      do_req(vt[i].s, vt[i].we, vt[i].a, vt[i].d, vt[i].be, rd, lat, oe_cyc, we_cyc, a_seen);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(2 + ws));
      chk($sformatf("v%0d_addr", i), 64'(a_seen), 64'(vt[i].a));
      chk($sformatf("v%0d_oe_cyc", i), 64'(oe_cyc), vt[i].we ? 64'd0 : 64'(ws + 2));
      chk($sformatf("v%0d_we_cyc", i), 64'(we_cyc), vt[i].we ? 64'(ws + 1) : 64'd0);
      if (vt[i].we) begin
        chk($sformatf("v%0d_hold_w", i), 64'({cs_n[vt[i].s], we_n[vt[i].s], dq_oe[vt[i].s]}), 64'b011);
        chk($sformatf("v%0d_rdata_kept", i), 64'(rd), 64'(last_rd[vt[i].s]));
      end else begin
        chk($sformatf("v%0d_hold_r", i), 64'({cs_n[vt[i].s], oe_n[vt[i].s], dq_oe[vt[i].s]}), 64'b110);
        chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].exp));
        last_rd[vt[i].s] = vt[i].exp;
      end
    end

    // Back-to-back with req_valid held: read, write, read on the 0-wait instance.
    bw[0] = 1'b0; bd[0] = 16'h0000; bexp[0] = 16'h1234;
    bw[1] = 1'b1; bd[1] = 16'hCAFE; bexp[1] = 16'h0000;
    bw[2] = 1'b0; bd[2] = 16'h0000; bexp[2] = 16'hCAFE;
    k = 0; nrsp = 0; rerr = 0;
    req_we[0] = bw[0]; req_addr[0] = 18'h00010; req_wdata[0] = bd[0]; req_be[0] = 2'b11;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 80 && nrsp < 3; c++) begin
      if (req_ready[0] !== (cs_n[0] && !rsp_valid[0])) rerr++;
      if (rsp_valid[0]) begin
        if (!bw[nrsp]) chk($sformatf("b2b_rd%0d", nrsp), 64'(rsp_rdata[0]), 64'(bexp[nrsp]));
        nrsp++;
      end
      acc = req_ready[0] && req_valid[0];
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 3) begin req_we[0] = bw[k]; req_wdata[0] = bd[k]; end
        else req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    chk("b2b_nrsp", 64'(nrsp), 64'd3);
    chk("b2b_ready_decode", 64'(rerr), 64'd0);

    // Reset during the ACCESS phase of a write on the 3-wait instance.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 18'h3FFFF;
    req_wdata[1] = 16'h7777; req_be[1] = 2'b11;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_access", 64'({we_n[1], dq_oe[1]}), 64'b01);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_strobes", 64'({cs_n[1], oe_n[1], we_n[1], dq_oe[1], be_n[1]}), 64'b111011);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid[1]) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    do_req(1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, rd, lat, oe_cyc, we_cyc, a_seen);
    chk("post_abort_lat", 64'(lat), 64'd5);
    chk("post_abort_rdata", 64'(rd), 64'hBE12);

    chk("bus_contention", 64'(cont_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
